int_exe_wb: RTL

- Execution-side counterpart of the integer issue queue.
- Accepts issued ops on slot0 (ALU/MUL) and slot1 (ALU/BJU), and tracks them through fixed-latency ALU stages and a non-pipelined iterative multiplier.
- Drives the writeback/wakeup broadcast (valid, need_to_wb, prd, robid) and the mul_slot_busy back-pressure.
- Only tags and control are modelled; datapath results are produced by the functional units and aligned to these writeback strobes.

---
 rtl/int_exe_wb.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/int_exe_wb.sv
// -----------------------------------------------------------------------------
// int_exe_wb
//
// Execution-side tag/control tracker for the integer pipe. It follows the ops
// issued by the integer issue queue through the single-cycle ALU stages and the
// non-pipelined iterative multiplier. It then drives the writeback/wakeup
// broadcast that the rename/ROB logic consumes. Datapath results come from the
// functional units and are aligned to the writeback strobes generated here.
//
// Optional feature:
//   INT_EXE_WB_PERF_EN - adds three free-running 32-bit performance counters:
//                        accepted ALU ops, accepted MUL ops, and flush-killed ops.
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   ex_slot0_valid/_T/_control/_robid  slot0 issue (ALU or MUL)
//   ex_slot1_valid/_T/_control/_robid  slot1 issue (ALU/BJU)
//   flush_valid, flush_robid           flush of everything younger than robid
//   mul_slot_busy                      multiplier cannot take a new op
//   writeback0_*                       ALU0 completion (valid, need_to_wb, prd, robid)
//   writeback1_*                       ALU1/BJU completion
//   writeback2_*                       MUL completion
//   perf_alu_cnt/_mul_cnt/_kill_cnt    performance counters (INT_EXE_WB_PERF_EN only)
// -----------------------------------------------------------------------------

package int_exe_wb_pkg;
    typedef struct packed {
        logic is_mul;
        logic reg_write;
    } control_type;
endpackage

module int_exe_wb
    import int_exe_wb_pkg::*;
#(
    parameter int PRF_WIDTH = 6,
    parameter int ROB_WIDTH = 5,
    parameter int MUL_LAT   = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 ex_slot0_valid,
    input  logic [PRF_WIDTH-1:0] slot0_T,
    input  control_type          slot0_control,
    input  logic [ROB_WIDTH:0]   slot0_robid,

    input  logic                 ex_slot1_valid,
    input  logic [PRF_WIDTH-1:0] slot1_T,
    input  control_type          slot1_control,
    input  logic [ROB_WIDTH:0]   slot1_robid,

    input  logic                 flush_valid,
    input  logic [ROB_WIDTH:0]   flush_robid,

    output logic                 mul_slot_busy,

    output logic                 writeback0_valid,
    output logic                 writeback0_need_to_wb,
    output logic [PRF_WIDTH-1:0] writeback0_prd,
    output logic [ROB_WIDTH:0]   writeback0_robid,

    output logic                 writeback1_valid,
    output logic                 writeback1_need_to_wb,
    output logic [PRF_WIDTH-1:0] writeback1_prd,
    output logic [ROB_WIDTH:0]   writeback1_robid,

    output logic                 writeback2_valid,
    output logic                 writeback2_need_to_wb,
    output logic [PRF_WIDTH-1:0] writeback2_prd,
    output logic [ROB_WIDTH:0]   writeback2_robid
`ifdef INT_EXE_WB_PERF_EN
    ,
    output logic [31:0]          perf_alu_cnt,
    output logic [31:0]          perf_mul_cnt,
    output logic [31:0]          perf_kill_cnt
`endif
);

    localparam int          CNT_W    = 4;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

    // Age compare across the ROB wrap bit: equal wrap bits compare the index
    // directly, differing wrap bits mean the index has wrapped past f.
    function automatic logic is_younger(input logic [ROB_WIDTH:0] r,
                                        input logic [ROB_WIDTH:0] f);
        if (r[ROB_WIDTH] == f[ROB_WIDTH])
            return r[ROB_WIDTH-1:0] > f[ROB_WIDTH-1:0];
        else
            return r[ROB_WIDTH-1:0] < f[ROB_WIDTH-1:0];
    endfunction

    logic [CNT_W-1:0]     mul_count;
    logic [PRF_WIDTH-1:0] mul_prd;
    logic [ROB_WIDTH:0]   mul_robid;
    logic                 mul_need_wb;

    logic slot0_kill;
    logic slot1_kill;
    logic mul_kill;
    logic alu0_accept;
    logic alu1_accept;
    logic mul_accept;
    logic mul_done;

    // The multiplier is occupied exactly while its count is non-zero, so the
    // counter doubles as the in-flight flag for the MUL entry.
    assign mul_slot_busy = (mul_count != '0);

    always_comb begin
        slot0_kill  = flush_valid & is_younger(slot0_robid, flush_robid);
        slot1_kill  = flush_valid & is_younger(slot1_robid, flush_robid);
        mul_kill    = flush_valid & mul_slot_busy & is_younger(mul_robid, flush_robid);
        alu0_accept = ex_slot0_valid & ~slot0_control.is_mul & ~slot0_kill;
        alu1_accept = ex_slot1_valid & ~slot1_kill;
        // A mul issued while busy is a protocol violation and is simply ignored.
        mul_accept  = ex_slot0_valid & slot0_control.is_mul & ~mul_slot_busy & ~slot0_kill;
        mul_done    = (mul_count == CNT_W'(1)) & ~mul_kill;
    end

    // ALU stages: one registered cycle from issue to writeback broadcast.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            writeback0_valid      <= 1'b0;
            writeback0_need_to_wb <= 1'b0;
            writeback0_prd        <= '0;
            writeback0_robid      <= '0;
            writeback1_valid      <= 1'b0;
            writeback1_need_to_wb <= 1'b0;
            writeback1_prd        <= '0;
            writeback1_robid      <= '0;
        end else begin
            writeback0_valid      <= alu0_accept;
            writeback0_need_to_wb <= alu0_accept & slot0_control.reg_write;
            writeback0_prd        <= alu0_accept ? slot0_T : '0;
            writeback0_robid      <= alu0_accept ? slot0_robid : '0;
            writeback1_valid      <= alu1_accept;
            writeback1_need_to_wb <= alu1_accept & slot1_control.reg_write;
            writeback1_prd        <= alu1_accept ? slot1_T : '0;
            writeback1_robid      <= alu1_accept ? slot1_robid : '0;
        end
    end

    // Multiplier tracker: load MUL_LAT-1 on accept and count down; the
    // writeback strobe is registered on the 1->0 step so it lands exactly
    // MUL_LAT cycles after issue, the same cycle busy drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_count   <= '0;
            mul_prd     <= '0;
            mul_robid   <= '0;
            mul_need_wb <= 1'b0;
        end else if (mul_kill) begin
            mul_count   <= '0;
        end else if (mul_accept) begin
            mul_count   <= MUL_LOAD;
            mul_prd     <= slot0_T;
            mul_robid   <= slot0_robid;
            mul_need_wb <= slot0_control.reg_write;
        end else if (mul_slot_busy) begin
            mul_count   <= mul_count - CNT_W'(1);
        end
    end

    // MUL writeback port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            writeback2_valid      <= 1'b0;
            writeback2_need_to_wb <= 1'b0;
            writeback2_prd        <= '0;
            writeback2_robid      <= '0;
        end else begin
            writeback2_valid      <= mul_done;
            writeback2_need_to_wb <= mul_done & mul_need_wb;
            writeback2_prd        <= mul_done ? mul_prd : '0;
            writeback2_robid      <= mul_done ? mul_robid : '0;
        end
    end

`ifdef INT_EXE_WB_PERF_EN
    logic       slot0_drop;
    logic       slot1_drop;
    logic [1:0] alu_inc;
    logic [1:0] kill_inc;

    // A dropped slot0 mul only counts if the multiplier would have taken it;
    // a mul issued while busy is ignored regardless of the flush.
    always_comb begin
        slot0_drop = ex_slot0_valid & slot0_kill & (~slot0_control.is_mul | ~mul_slot_busy);
        slot1_drop = ex_slot1_valid & slot1_kill;
        alu_inc    = 2'(alu0_accept) + 2'(alu1_accept);
        kill_inc   = 2'(slot0_drop) + 2'(slot1_drop) + 2'(mul_kill);
    end

    // Free-running counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_alu_cnt  <= '0;
            perf_mul_cnt  <= '0;
            perf_kill_cnt <= '0;
        end else begin
            perf_alu_cnt  <= perf_alu_cnt + {30'd0, alu_inc};
            perf_mul_cnt  <= perf_mul_cnt + {31'd0, mul_accept};
            perf_kill_cnt <= perf_kill_cnt + {30'd0, kill_inc};
        end
    end
`endif

endmodule
